// File: rtl/hqm_system_rf_fifo_pkg.sv
// Shared constants and types for the 256x10 system-memory RF FIFO controller.
package hqm_system_rf_fifo_pkg;

  localparam int DEPTH  = 256;
  localparam int DWIDTH = 10;
  localparam int AWIDTH = 8;
  localparam int HWM    = 192;

  // RF pointer, RF-resident count (0..DEPTH) and total occupancy (0..DEPTH+2)
  typedef logic [AWIDTH-1:0] rf_ptr_t;
  typedef logic [AWIDTH:0]   rf_cnt_t;
  typedef logic [AWIDTH+1:0] occ_t;
  typedef logic [DWIDTH-1:0] data_t;

  localparam rf_cnt_t RF_FULL  = rf_cnt_t'(DEPTH);
  localparam occ_t    HWM_OCC  = occ_t'(HWM);

  // Underflow checking is armed whenever the error build is selected
  localparam logic    UNF_CHK_EN = 1'b1;

  // Prefetch buffer operation for a cycle: {push, pop}
  typedef enum logic [1:0] {
    PF_IDLE = 2'b00,
    PF_POP  = 2'b01,
    PF_PUSH = 2'b10,
    PF_BOTH = 2'b11
  } pf_op_e;

  // DEPTH is a power of two, so natural overflow performs the DEPTH-1 -> 0 wrap
  function automatic rf_ptr_t ptr_inc(input rf_ptr_t p);
    return p + rf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/hqm_system_rf_fifo_prefetch.sv
// 2-entry output buffer that holds RF read returns; entry 0 is the FIFO head.
module hqm_system_rf_fifo_prefetch
  import hqm_system_rf_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  data_t       push_data_i,
  input  logic        pop_i,
  output data_t       head_o,
  output logic        valid_o,
  output logic [1:0]  cnt_o
);

  logic [1:0] cnt_q, cnt_d;
  data_t      e0_q, e0_d;
  data_t      e1_q, e1_d;
  logic       pop_ok_s;
  logic       push_ok_s;
  pf_op_e     op_s;

  // Qualify requests: never pop an empty buffer, never overfill without a pop
  always_comb begin
    pop_ok_s  = pop_i & (cnt_q != 2'd0);
    push_ok_s = push_i & ((cnt_q != 2'd2) | pop_ok_s);
    op_s      = pf_op_e'({push_ok_s, pop_ok_s});
  end

  // Next-state for the two entries and the count
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case (op_s)
      PF_IDLE: begin
        cnt_d = cnt_q;
      end
      PF_PUSH: begin
        if (cnt_q == 2'd0) begin
          e0_d = push_data_i;
        end else begin
          e1_d = push_data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      PF_POP: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      PF_BOTH: begin
        // Count is 1 or 2 here; the new entry lands behind whatever remains
        if (cnt_q == 2'd1) begin
          e0_d = push_data_i;
        end else begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Buffer state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/hqm_system_rf_256x10_fifo_ctl.sv
// FIFO controller owning the write/read ports of the 256x10 system RF.
// RF read latency is hidden by a 2-entry prefetch buffer so pops run at full rate.
// Optional sticky error flags are built when HQM_RF_FIFO_ERR_EN is defined;
// otherwise err_ovf/err_unf are tied low.
module hqm_system_rf_256x10_fifo_ctl
  import hqm_system_rf_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_v,
  input  logic [DWIDTH-1:0] push_data,
  output logic              push_ready,
  output logic              pop_v,
  output logic [DWIDTH-1:0] pop_data,
  input  logic              pop_ready,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              rf_re,
  output logic [AWIDTH-1:0] rf_raddr,
  input  logic [DWIDTH-1:0] rf_rdata,
  output logic [AWIDTH+1:0] occupancy,
  output logic              hwm,
  output logic              err_ovf,
  output logic              err_unf
);

  rf_ptr_t    wptr_q, wptr_d;
  rf_ptr_t    rptr_q, rptr_d;
  rf_cnt_t    rf_cnt_q, rf_cnt_d;
  logic       inflight_q, inflight_d;
  occ_t       occ_q, occ_d;
  logic       hwm_q, hwm_d;

  logic       push_ready_s;
  logic       push_fire_s;
  logic       pop_fire_s;
  logic       rd_issue_s;
  logic [2:0] pend_s;
  logic [1:0] ob_cnt_s;
  logic       ob_valid_s;
  data_t      ob_head_s;

  // Handshakes and RF read issue; rf_cnt is registered so a just-written entry is never read
  always_comb begin
    push_ready_s = (rf_cnt_q != RF_FULL);
    push_fire_s  = rst_n & push_v & push_ready_s;
    pop_fire_s   = rst_n & ob_valid_s & pop_ready;
    pend_s       = {1'b0, ob_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_fire_s};
    rd_issue_s   = rst_n & (rf_cnt_q != rf_cnt_t'(0)) & (pend_s < 3'd2);
  end

  // Pointer, RF count, in-flight and occupancy next-state
  always_comb begin
    if (push_fire_s) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_issue_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_fire_s, rd_issue_s})
      2'b10:   rf_cnt_d = rf_cnt_q + rf_cnt_t'(1);
      2'b01:   rf_cnt_d = rf_cnt_q - rf_cnt_t'(1);
      default: rf_cnt_d = rf_cnt_q;
    endcase

    inflight_d = rd_issue_s;

    case ({push_fire_s, pop_fire_s})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase

    // Computed from next occupancy so hwm and occupancy change on the same edge
    hwm_d = (occ_d >= HWM_OCC);
  end

  // Control state registers; reset discards contents but leaves the RF untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rf_cnt_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      hwm_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rf_cnt_q   <= rf_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      hwm_q      <= hwm_d;
    end
  end

  // RF returns land in the prefetch buffer the cycle after the read issue
  hqm_system_rf_fifo_prefetch u_prefetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (rf_rdata),
    .pop_i       (pop_fire_s),
    .head_o      (ob_head_s),
    .valid_o     (ob_valid_s),
    .cnt_o       (ob_cnt_s)
  );

  assign push_ready = push_ready_s;
  assign pop_v      = ob_valid_s;
  assign pop_data   = ob_head_s;
  assign rf_we      = push_fire_s;
  assign rf_waddr   = wptr_q;
  assign rf_wdata   = push_data;
  assign rf_re      = rd_issue_s;
  assign rf_raddr   = rptr_q;
  assign occupancy  = occ_q;
  assign hwm        = hwm_q;

`ifdef HQM_RF_FIFO_ERR_EN
  logic err_ovf_q;
  logic err_unf_q;

  // Sticky overflow/underflow flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      if (push_v & ~push_ready_s) begin
        err_ovf_q <= 1'b1;
      end else begin
        err_ovf_q <= err_ovf_q;
      end
      if (UNF_CHK_EN & pop_ready & ~ob_valid_s) begin
        err_unf_q <= 1'b1;
      end else begin
        err_unf_q <= err_unf_q;
      end
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_system_rf_256x10_fifo_ctl.sv
// Self-checking bench for hqm_system_rf_256x10_fifo_ctl with a behavioural RF
// and an in-order queue reference model of the FIFO.
module tb_hqm_system_rf_256x10_fifo_ctl;
  import hqm_system_rf_fifo_pkg::*;

`ifdef HQM_RF_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push_v = 1'b0;
  logic [DWIDTH-1:0] push_data = '0;
  logic              push_ready;
  logic              pop_v;
  logic [DWIDTH-1:0] pop_data;
  logic              pop_ready = 1'b0;
  logic              rf_we;
  logic [AWIDTH-1:0] rf_waddr;
  logic [DWIDTH-1:0] rf_wdata;
  logic              rf_re;
  logic [AWIDTH-1:0] rf_raddr;
  logic [DWIDTH-1:0] rf_rdata = '0;
  logic [AWIDTH+1:0] occupancy;
  logic              hwm;
  logic              err_ovf;
  logic              err_unf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DWIDTH-1:0] q_data[$];
  int                q_time[$];
  logic              pfire;
  logic              popfire;
  logic [DWIDTH-1:0] rf_mem [DEPTH];

  hqm_system_rf_256x10_fifo_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_v    (push_v),
    .push_data (push_data),
    .push_ready(push_ready),
    .pop_v     (pop_v),
    .pop_data  (pop_data),
    .pop_ready (pop_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_re     (rf_re),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .occupancy (occupancy),
    .hwm       (hwm),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 clk = ~clk;

  // Behavioural 256x10 RF: synchronous write, 1-cycle registered read
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    if (rf_re) rf_rdata <= rf_mem[rf_raddr];
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rf_mem[i] = '0;
  end

  // Apply inputs away from the edge and note which handshakes will fire
  task automatic drive(input logic pv, input logic [DWIDTH-1:0] pd, input logic pr);
    @(negedge clk);
    push_v    = pv;
    push_data = pd;
    pop_ready = pr;
    #1;
    pfire   = rst_n && push_v && push_ready;
    popfire = rst_n && pop_v && pop_ready;
  endtask

  // Clock edge: update the reference queue with the handshakes that fired
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      q_data.delete();
      q_time.delete();
    end else begin
      if (popfire && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_time.pop_front());
      end
      if (pfire) begin
        q_data.push_back(push_data);
        q_time.push_back(cyc);
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    step();
    @(negedge clk); #1;
    n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    n_vec++; if (pop_v !== 1'b0) begin n_err++; $display("FAIL reset_pop_v got=%b exp=0", pop_v); end
    n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    n_vec++; if ({hwm, err_ovf, err_unf} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {hwm, err_ovf, err_unf}); end
    n_vec++; if ({rf_we, rf_re, rf_waddr, rf_raddr} !== 18'd0) begin n_err++; $display("FAIL reset_rf_ports got=%h exp=0", {rf_we, rf_re, rf_waddr, rf_raddr}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 10'h3A1, 1'b1);
      n_vec++; if (rf_we !== (c == 0)) begin n_err++; $display("FAIL single_rf_we c=%0d got=%b", c, rf_we); end
      if (c == 0) begin
        n_vec++; if ({rf_waddr, rf_wdata} !== {8'd0, 10'h3A1}) begin n_err++; $display("FAIL single_wr got=%h/%h exp=0/3a1", rf_waddr, rf_wdata); end
      end
      n_vec++; if (rf_re !== (c == 1)) begin n_err++; $display("FAIL single_rf_re c=%0d got=%b", c, rf_re); end
      n_vec++; if (pop_v !== (c == 3)) begin n_err++; $display("FAIL single_pop_v c=%0d got=%b", c, pop_v); end
      if (c == 3) begin
        n_vec++; if (pop_data !== 10'h3A1) begin n_err++; $display("FAIL single_pop_data got=%h exp=3a1", pop_data); end
      end
      n_vec++; if (occupancy !== (AWIDTH+2)'(q_data.size())) begin n_err++; $display("FAIL single_occ c=%0d got=%0d exp=%0d", c, occupancy, q_data.size()); end
      step();
    end
    @(negedge clk); #1;
    n_vec++; if (err_unf !== ERR_EN) begin n_err++; $display("FAIL single_err_unf got=%b exp=%b", err_unf, ERR_EN); end
  endtask

  task automatic test_fill();
    for (int n = 0; n < DEPTH + 2; n++) begin
      drive(1'b1, DWIDTH'($urandom), 1'b0);
      n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready n=%0d got=%b exp=1", n, push_ready); end
      n_vec++; if (hwm !== (q_data.size() >= HWM)) begin n_err++; $display("FAIL fill_hwm occ=%0d got=%b", q_data.size(), hwm); end
      step();
    end
    drive(1'b1, 10'h155, 1'b0);
    n_vec++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", push_ready); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL full_rf_we got=%b exp=0", rf_we); end
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (occupancy !== (AWIDTH+2)'(q_data.size()) || q_data.size() != DEPTH + 2) begin n_err++; $display("FAIL full_occ got=%0d exp=%0d", occupancy, DEPTH + 2); end
    n_vec++; if (hwm !== 1'b1) begin n_err++; $display("FAIL full_hwm got=%b exp=1", hwm); end
    n_vec++; if (err_ovf !== ERR_EN) begin n_err++; $display("FAIL full_err_ovf got=%b exp=%b", err_ovf, ERR_EN); end
    step();
  endtask

  task automatic test_drain();
    for (int n = 0; n < DEPTH + 2; n++) begin
      drive(1'b0, '0, 1'b1);
      n_vec++; if (pop_v !== 1'b1) begin n_err++; $display("FAIL drain_pop_v n=%0d got=%b exp=1", n, pop_v); end
      n_vec++; if (q_data.size() == 0 || pop_data !== q_data[0]) begin n_err++; $display("FAIL drain_data n=%0d got=%h", n, pop_data); end
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (pop_v !== 1'b0 || occupancy !== '0) begin n_err++; $display("FAIL drain_end got pop_v=%b occ=%0d exp 0/0", pop_v, occupancy); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, DWIDTH'(i), 1'b1);
      n_vec++; if (occupancy !== (AWIDTH+2)'(q_data.size())) begin n_err++; $display("FAIL b2b_occ i=%0d got=%0d exp=%0d", i, occupancy, q_data.size()); end
      if (i >= 3) begin
        n_vec++; if (pop_v !== 1'b1) begin n_err++; $display("FAIL b2b_bubble i=%0d got=%b exp=1", i, pop_v); end
        n_vec++; if (q_data.size() == 0 || pop_data !== q_data[0]) begin n_err++; $display("FAIL b2b_data i=%0d got=%h", i, pop_data); end
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1);
      step();
    end
    @(negedge clk); #1;
    n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL b2b_end_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), DWIDTH'($urandom), 1'($urandom_range(0, 1)));
      n_vec++; if (occupancy !== (AWIDTH+2)'(q_data.size())) begin n_err++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, q_data.size()); end
      n_vec++; if (hwm !== (q_data.size() >= HWM)) begin n_err++; $display("FAIL rnd_hwm i=%0d got=%b", i, hwm); end
      if (q_data.size() == 0) begin
        n_vec++; if (pop_v !== 1'b0) begin n_err++; $display("FAIL rnd_empty_pop_v i=%0d got=%b exp=0", i, pop_v); end
      end else begin
        if (cyc - q_time[0] >= 3) begin
          n_vec++; if (pop_v !== 1'b1) begin n_err++; $display("FAIL rnd_pop_v_late i=%0d got=%b exp=1", i, pop_v); end
        end
        if (pop_v === 1'b1) begin
          n_vec++; if (pop_data !== q_data[0]) begin n_err++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, pop_data, q_data[0]); end
        end
      end
      if (q_data.size() < DEPTH) begin
        n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready i=%0d got=%b exp=1", i, push_ready); end
      end
      if (rf_we === 1'b1 && rf_re === 1'b1) begin
        n_vec++; if (rf_waddr === rf_raddr) begin n_err++; $display("FAIL rnd_collision i=%0d got addr=%h exp distinct", i, rf_waddr); end
      end
      step();
    end
  endtask

  task automatic test_midreset();
    while (q_data.size() < 100) begin
      drive(1'b1, DWIDTH'($urandom), 1'b0);
      step();
    end
    while (q_data.size() > 100) begin
      drive(1'b0, '0, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (occupancy !== 10'd100) begin n_err++; $display("FAIL mid_pre_occ got=%0d exp=100", occupancy); end
    step();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1);
    step();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    n_vec++; if (pop_v !== 1'b0) begin n_err++; $display("FAIL mid_pop_v got=%b exp=0", pop_v); end
    n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL mid_push_ready got=%b exp=1", push_ready); end
    n_vec++; if ({err_ovf, err_unf} !== 2'b00) begin n_err++; $display("FAIL mid_err got=%b exp=00", {err_ovf, err_unf}); end
    step();
    for (int i = 0; i < 12; i++) begin
      drive(i < 5, DWIDTH'(10'h200 + i), i >= 3);
      if (pop_v === 1'b1) begin
        n_vec++; if (q_data.size() == 0 || pop_data !== q_data[0]) begin n_err++; $display("FAIL mid_fresh_data i=%0d got=%h", i, pop_data); end
      end
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (occupancy !== '0 || q_data.size() != 0) begin n_err++; $display("FAIL mid_end_occ got=%0d exp=0", occupancy); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
